// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI command responder with local register file and read-back frame; optional err_cnt via SPI_SLV_ERR_CNT_EN
module spi_reg_slave #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int RD_GAP_MAX = 200,
    parameter logic [DATA_WIDTH-1:0] REG_RST_VAL = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                sclk,
    input  logic                                cs,
    input  logic                                mosi,
    output logic                                miso,
    output logic [DATA_WIDTH*2**ADDR_WIDTH-1:0] regs_flat,
    output logic                                wr_pulse,
    output logic [ADDR_WIDTH-1:0]               wr_addr,
    output logic                                rd_pulse
`ifdef SPI_SLV_ERR_CNT_EN
    ,
    output logic [7:0]                          err_cnt
`endif
);
    localparam int CMD_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam int CW = $clog2(CMD_WIDTH + 1);
    localparam int GW = $clog2(RD_GAP_MAX + 1);
    localparam logic [CW-1:0] CMD_LEN = CW'(CMD_WIDTH);
    localparam logic [CW-1:0] DW_LEN = CW'(DATA_WIDTH);
    localparam logic [GW-1:0] GAP_MAX = GW'(RD_GAP_MAX);

    typedef enum logic [2:0] {IDLE, CMD, WR_COMMIT, RD_WAIT, RD_SEND} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              sclk_sy_q, cs_sy_q;
    logic [1:0]              mosi_sy_q;
    logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
    logic [CMD_WIDTH-1:0]    sh_q, sh_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic                    wr_pulse_q, wr_pulse_d, rd_pulse_q, rd_pulse_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   reg_q [NREG];
    logic [DATA_WIDTH-1:0]   reg_d [NREG];

    wire sclk_rise = sclk_sy_q[1] & ~sclk_sy_q[2];
    wire sclk_fall = ~sclk_sy_q[1] & sclk_sy_q[2];
    wire cs_fall   = ~cs_sy_q[1] & cs_sy_q[2];
    wire cs_rise   = cs_sy_q[1] & ~cs_sy_q[2];
    wire mosi_s    = mosi_sy_q[1];
    wire                  cmd_rw   = sh_q[CMD_WIDTH-1];
    wire [ADDR_WIDTH-1:0] cmd_addr = sh_q[CMD_WIDTH-2 -: ADDR_WIDTH];
    wire [DATA_WIDTH-1:0] cmd_data = sh_q[DATA_WIDTH-1:0];

    // Pin synchronisers; the third stage of sclk/cs keeps the previous value for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sy_q <= 3'b000;
            cs_sy_q   <= 3'b111;
            mosi_sy_q <= 2'b00;
        end else begin
            sclk_sy_q <= {sclk_sy_q[1:0], sclk};
            cs_sy_q   <= {cs_sy_q[1:0], cs};
            mosi_sy_q <= {mosi_sy_q[0], mosi};
        end
    end

    // Frame FSM: command capture, write commit, read wait and read shift-out
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = '0;
        sh_d       = sh_q;
        tx_d       = tx_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        rd_pulse_d = 1'b0;
        reg_d      = reg_q;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                    sh_d      = '0;
                end
            end
            CMD: begin
                if (cs_rise) begin
                    state_d = (bit_cnt_q != CMD_LEN) ? IDLE : (cmd_rw ? WR_COMMIT : RD_WAIT);
                    tx_d    = reg_q[cmd_addr];
                end else if (sclk_rise && bit_cnt_q != CMD_LEN) begin
                    sh_d      = {mosi_s, sh_q[CMD_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            WR_COMMIT: begin
                reg_d[cmd_addr] = cmd_data;
                wr_pulse_d      = 1'b1;
                wr_addr_d       = cmd_addr;
                state_d         = IDLE;
            end
            RD_WAIT: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (cs_fall) begin
                    state_d   = RD_SEND;
                    bit_cnt_d = '0;
                end else if (gap_cnt_q == GAP_MAX) begin
                    state_d = IDLE;
                end
            end
            RD_SEND: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else begin
                    if (sclk_fall) tx_d = tx_q >> 1;
                    if (sclk_rise && bit_cnt_q != DW_LEN) begin
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        rd_pulse_d = (bit_cnt_q == DW_LEN - 1'b1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            sh_q       <= '0;
            tx_q       <= '0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            rd_pulse_q <= 1'b0;
            for (int k = 0; k < NREG; k++) reg_q[k] <= REG_RST_VAL;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            sh_q       <= sh_d;
            tx_q       <= tx_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            rd_pulse_q <= rd_pulse_d;
            reg_q      <= reg_d;
        end
    end

    for (genvar i = 0; i < NREG; i++) begin : g_flat
        assign regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = reg_q[i];
    end

    assign miso     = (state_q == RD_SEND) ? tx_q[0] : 1'b0;
    assign wr_pulse = wr_pulse_q;
    assign wr_addr  = wr_addr_q;
    assign rd_pulse = rd_pulse_q;

`ifdef SPI_SLV_ERR_CNT_EN
    logic       err;
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating count of discarded commands, read timeouts and aborted reads
    always_comb begin
        err = (state_q == CMD && cs_rise && bit_cnt_q != CMD_LEN) ||
              (state_q == RD_WAIT && !cs_fall && gap_cnt_q == GAP_MAX) ||
              (state_q == RD_SEND && cs_rise && bit_cnt_q != DW_LEN);
        err_cnt_d = (err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    // Error counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= 8'd0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: randomized self-checking bench for spi_reg_slave against a register-array model
module tb_spi_reg_slave;
    logic        clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
    logic        miso, wr_pulse, rd_pulse;
    logic [63:0] regs_flat;
    logic [2:0]  wr_addr;
`ifdef SPI_SLV_ERR_CNT_EN
    logic [7:0]  err_cnt;
    int          exp_err = 0;
`endif
    int          total = 0, bad = 0;
    int          wr_seen = 0, rd_seen = 0;
    logic [2:0]  last_wa = '0;
    logic [7:0]  mdl [8];

    always #5 clk = ~clk;

    spi_reg_slave dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .regs_flat(regs_flat), .wr_pulse(wr_pulse), .wr_addr(wr_addr), .rd_pulse(rd_pulse)
`ifdef SPI_SLV_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    // Count output pulses and remember the last write address
    always @(posedge clk) begin
        if (wr_pulse) begin
            wr_seen = wr_seen + 1;
            last_wa = wr_addr;
        end
        if (rd_pulse) rd_seen = rd_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (10) @(negedge clk);
    endtask

    task automatic send(input logic [11:0] c, input int n);
        cs = 1'b0;
        half();
        for (int i = 0; i < n; i++) begin
            mosi = c[i];
            half();
            sclk = 1'b1;
            half();
            sclk = 1'b0;
        end
        half();
        cs = 1'b1;
        half();
    endtask

    task automatic recv(output logic [7:0] b);
        cs = 1'b0;
        half();
        for (int i = 0; i < 8; i++) begin
            b[i] = miso;
            mosi = 1'($urandom);
            sclk = 1'b1;
            half();
            sclk = 1'b0;
            half();
        end
        cs = 1'b1;
        half();
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) check(tag, regs_flat[i*8 +: 8], mdl[i]);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        int w0;
        w0 = wr_seen;
        send({1'b1, a, d}, 12);
        mdl[a] = d;
        check("wr_pulse_cnt", wr_seen - w0, 1);
        check("wr_addr", last_wa, a);
    endtask

    task automatic do_read(input logic [2:0] a, input int gap);
        logic [7:0] b;
        int r0;
        r0 = rd_seen;
        send({1'b0, a, 8'($urandom)}, 12);
        repeat (gap) @(negedge clk);
        recv(b);
        check("rd_data", b, mdl[a]);
        check("rd_pulse_cnt", rd_seen - r0, 1);
    endtask

    initial begin
        int w0, r0;
        logic seen;
        logic [7:0] b;
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        repeat (4) @(negedge clk);
        check("rst_miso", miso, 0);
        check("rst_wr_pulse", wr_pulse, 0);
        check("rst_rd_pulse", rd_pulse, 0);
        check("rst_wr_addr", wr_addr, 0);
        check_regs("rst_reg");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        do_write(3'd5, 8'hA7);
        check_regs("t1_reg");
        do_read(3'd5, 50);

        w0 = wr_seen;
        send({1'b1, 3'd2, 8'h5A}, 9);
        check("t3_no_pulse", wr_seen - w0, 0);
        check_regs("t3_reg");
`ifdef SPI_SLV_ERR_CNT_EN
        exp_err++;
        check("t3_err", err_cnt, exp_err);
`endif

        r0 = rd_seen;
        send({1'b0, 3'd5, 8'h00}, 12);
        seen = 1'b0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            seen = seen | miso;
        end
        check("t4_miso_idle", seen, 0);
        check("t4_no_rd", rd_seen - r0, 0);
`ifdef SPI_SLV_ERR_CNT_EN
        exp_err++;
        check("t4_err", err_cnt, exp_err);
`endif
        do_write(3'd6, 8'h42);
        check_regs("t4_reg");

        w0 = wr_seen;
        for (int i = 0; i < 8; i++) begin
            send({1'b1, 3'(i), 8'(8'h11 * i)}, 12);
            mdl[i] = 8'(8'h11 * i);
            repeat (3) half();
        end
        check("t5_pulses", wr_seen - w0, 8);
        check_regs("t5_reg");

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(1, 0) == 1) do_write(3'($urandom), 8'($urandom));
            else do_read(3'($urandom), $urandom_range(150, 5));
        end
        check_regs("rand_reg");

        send({1'b0, 3'd3, 8'h00}, 12);
        cs = 1'b0;
        half();
        for (int i = 0; i < 4; i++) begin
            b[i] = miso;
            sclk = 1'b1;
            half();
            sclk = 1'b0;
            half();
        end
        check("t6_pre_bits", b[3:0], mdl[3][3:0]);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        check("t6_miso", miso, 0);
        check_regs("t6_rst_reg");
`ifdef SPI_SLV_ERR_CNT_EN
        exp_err = 0;
        check("t6_err", err_cnt, exp_err);
`endif
        cs = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        do_write(3'd1, 8'h3C);
        check_regs("t6_reg");
        do_read(3'd1, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
